// File: rtl/smoke_bfm_sched.sv
// Round-robin scheduler sharing one smoke BFM command/response channel among N_REQ
// requesters; one transaction in flight, responses routed to the originator, watchdog on silence.
module smoke_bfm_sched #(
    parameter int N_REQ   = 4,
    parameter int CMD_W   = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*CMD_W-1:0]   req_cmd,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         rsp_valid,
    input  logic [N_REQ-1:0]         rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_err,
    output logic                     bfm_cmd_valid,
    input  logic                     bfm_cmd_ready,
    output logic [CMD_W-1:0]         bfm_cmd,
    output logic [DATA_W-1:0]        bfm_data,
    input  logic                     bfm_rsp_valid,
    input  logic [DATA_W-1:0]        bfm_rsp_data,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] data;
    } bfm_req_t;

    state_e            state_q, state_d;
    bfm_req_t          req_q, req_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d, gnt_q, gnt_d, pick, idx;
    logic              req_any;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    // Scan from the farthest offset down so the nearest valid requester after ptr wins.
    always_comb begin
        pick    = '0;
        idx     = '0;
        req_any = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = IDX_W'((int'(ptr_q) + k) % N_REQ);
            if (req_valid[idx]) begin
                pick    = idx;
                req_any = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = '0;
        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    req_ready[pick] = 1'b1;
                    req_d.cmd  = CMD_W'(req_cmd >> (int'(pick) * CMD_W));
                    req_d.data = DATA_W'(req_data >> (int'(pick) * DATA_W));
                    gnt_d      = pick;
                    ptr_d      = pick;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (bfm_cmd_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (TIMEOUT != 0) cnt_d = cnt_q + 1'b1;
                // A response arriving on the final watchdog cycle still wins.
                if (bfm_rsp_valid) begin
                    rdata_d = bfm_rsp_data;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[gnt_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            ptr_q   <= IDX_W'(N_REQ - 1);
            gnt_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_rsp
        assign rsp_valid[i] = (state_q == RESP) && (gnt_q == IDX_W'(i));
    end

    assign bfm_cmd_valid = (state_q == ISSUE);
    assign bfm_cmd       = req_q.cmd;
    assign bfm_data      = req_q.data;
    assign rsp_data      = rdata_q;
    assign rsp_err       = err_q;
    assign busy          = (state_q != IDLE);
    assign grant_id      = gnt_q;

endmodule
